wb_regfile: RTL

- Writeback-stage consumer of the MEM/WB pipeline register, plus the 32-entry general register file.
- Selects the writeback value: load data, ALU result, or jal link value.
- Selects the destination: the instruction's rd/rt, or $31 for jal.
- Commits the write on the clock edge and serves two ID-stage read ports with same-cycle write-through bypass.
- Also counts committed register writes for the performance/debug view.

---
 rtl/wb_regfile.sv | 98 +++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Writeback stage and 32-entry general register file: selects the writeback
// value and destination, commits on the clock edge, and serves two bypassed read ports.
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int LINK_REG   = 31,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  memtoreg,
    input  logic                  regwrite,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic [DATA_WIDTH-1:0] alures,
    input  logic [4:0]            mux_1,
    input  logic                  jal,
    input  logic [DATA_WIDTH-1:0] add_res,
    input  logic [4:0]            read_reg1,
    input  logic [4:0]            read_reg2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic [4:0]            dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic [CNT_WIDTH-1:0]  wb_count
);

    localparam logic [4:0] LINK_IDX = 5'(LINK_REG);

    logic [DATA_WIDTH-1:0] regs_r [0:31];
    logic [DATA_WIDTH-1:0] dbg_data_r;
    logic [CNT_WIDTH-1:0]  wb_count_r;
    logic [4:0]            wb_dest_s;
    logic [DATA_WIDTH-1:0] wb_value_s;
    logic                  we_s;

    // Writeback destination/value selection and commit enable
    always_comb begin
        wb_dest_s  = mux_1;
        wb_value_s = alures;
        if (jal) begin
            wb_dest_s  = LINK_IDX;
            wb_value_s = add_res;
        end else if (memtoreg) begin
            wb_value_s = read_data;
        end else begin
            wb_value_s = alures;
        end
        // Gating on regwrite first keeps undefined payload inputs from committing.
        we_s = regwrite & (wb_dest_s != 5'd0) & ~reset;
    end

    // Read port 1 with write-through bypass; address 0 always reads zero
    always_comb begin
        read_data1 = {DATA_WIDTH{1'b0}};
        if (reset || (read_reg1 == 5'd0)) begin
            read_data1 = {DATA_WIDTH{1'b0}};
        end else if (we_s && (read_reg1 == wb_dest_s)) begin
            read_data1 = wb_value_s;
        end else begin
            read_data1 = regs_r[read_reg1];
        end
    end

    // Read port 2 with write-through bypass; address 0 always reads zero
    always_comb begin
        read_data2 = {DATA_WIDTH{1'b0}};
        if (reset || (read_reg2 == 5'd0)) begin
            read_data2 = {DATA_WIDTH{1'b0}};
        end else if (we_s && (read_reg2 == wb_dest_s)) begin
            read_data2 = wb_value_s;
        end else begin
            read_data2 = regs_r[read_reg2];
        end
    end

    // Register array commit, debug snapshot and committed-write counter
    always_ff @(posedge Clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
            dbg_data_r <= {DATA_WIDTH{1'b0}};
            wb_count_r <= {CNT_WIDTH{1'b0}};
        end else begin
            // Debug view samples the array before this edge's write lands.
            dbg_data_r <= regs_r[dbg_addr];
            if (we_s) begin
                regs_r[wb_dest_s] <= wb_value_s;
                wb_count_r        <= wb_count_r + CNT_WIDTH'(1);
            end else begin
                wb_count_r        <= wb_count_r;
            end
        end
    end

    assign dbg_data = dbg_data_r;
    assign wb_count = wb_count_r;

endmodule
